// File: rtl/key_scan_pkg.sv
// Shared keypad geometry and helpers for the key_scan block.
package key_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int CODE_W   = 4;

  typedef logic [CODE_W-1:0] code_t;

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debounce counter: counts consecutive disagreeing samples.
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic closed,
  input  logic state,
  input  logic flip,
  output logic eligible
);

  localparam logic [2:0] SAT = 3'(DEBOUNCE_SCANS);

  logic [2:0] cnt;
  logic [2:0] nxt;

  always_comb begin
    nxt = cnt;
    if (closed == state) nxt = 3'd0;
    else if (cnt != SAT) nxt = cnt + 3'd1;
  end

  // SAT >= 1, so reaching it implies the sample disagrees with state
  assign eligible = sample && (nxt == SAT);

  always_ff @(posedge clk) begin
    if (reset) cnt <= 3'd0;
    else if (flip) cnt <= 3'd0;
    else if (sample) cnt <= nxt;
  end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: column drive, debounce, one-at-a-time key events.
module key_scan
  import key_scan_pkg::*;
#(
  parameter int DWELL_BITS     = 16,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] krow,
  output logic [NUM_COLS-1:0] kcol,
  output logic [15:0]         keys,
  output logic                ev_valid,
  input  logic                ev_ready,
  output code_t               ev_code,
  output logic                ev_press
);

  localparam int CW = DWELL_BITS + 2;

  logic [NUM_ROWS-1:0] sync1, sync2;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [1:0]          col, col_nxt;
  logic                sample;
  logic [15:0]         elig, flip;
  logic                any, go;
  code_t               sel;

  assign cnt_nxt = cnt + CW'(1);
  assign col     = cnt[CW-1 -: 2];
  assign col_nxt = cnt_nxt[CW-1 -: 2];
  assign sample  = &cnt[DWELL_BITS-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      cnt   <= '0;
      kcol  <= col_drive(2'd0);
    end else begin
      sync1 <= krow;
      sync2 <= sync1;
      cnt   <= cnt_nxt;
      kcol  <= col_drive(col_nxt);
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_deb (
        .clk     (clk),
        .reset   (reset),
        .sample  (sample && (col == 2'(c))),
        .closed  (~sync2[r]),
        .state   (keys[c*NUM_ROWS+r]),
        .flip    (flip[c*NUM_ROWS+r]),
        .eligible(elig[c*NUM_ROWS+r])
      );
    end
  end

  // only one column is sampled at a time, so lowest index = lowest row
  always_comb begin
    any = 1'b0;
    sel = '0;
    for (int i = 15; i >= 0; i--) begin
      if (elig[i]) begin
        any = 1'b1;
        sel = code_t'(i);
      end
    end
  end

  assign go   = any && (!ev_valid || ev_ready);
  assign flip = go ? (16'd1 << sel) : 16'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      keys     <= '0;
      ev_valid <= 1'b0;
      ev_code  <= '0;
      ev_press <= 1'b0;
    end else begin
      keys <= keys ^ flip;
      if (go) begin
        ev_valid <= 1'b1;
        ev_code  <= sel;
        ev_press <= ~keys[sel];
      end else if (ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule
